// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Decodes ALU control and datapath strobes from a latched IR, handshakes on
// dReady in MEM, counts retired instructions and traps on illegal opcodes.
// Optional build macro MC_CTRL_TIMEOUT_EN adds a data-memory timeout trap.
module mc_ctrl_fsm #(
    parameter logic [31:0] INITIAL_IR  = 32'h0000_0013,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 Zero,
    input  logic                 dReady,
    output logic                 IRWrite,
    output logic                 loadPC,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic [3:0]           ALUCtrl,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemToReg,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic                 mem_err,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_ir;
    logic [INSTRET_W-1:0]   r_instret;
    logic                   r_illegal;

    logic [6:0]             w_opcode;
    logic [2:0]             w_funct3;
    logic [6:0]             w_funct7;
    logic                   w_is_r;
    logic                   w_is_i;
    logic                   w_is_lw;
    logic                   w_is_sw;
    logic                   w_is_br;
    logic                   w_uses_imm;
    logic                   w_legal;
    logic [3:0]             w_alu_dec;
    logic                   w_mem_timeout;
    logic                   w_unused;

    assign w_opcode   = r_ir[6:0];
    assign w_funct3   = r_ir[14:12];
    assign w_funct7   = r_ir[31:25];
    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_i     = (w_opcode == OP_I);
    assign w_is_lw    = (w_opcode == OP_LW);
    assign w_is_sw    = (w_opcode == OP_SW);
    assign w_is_br    = (w_opcode == OP_BR);
    assign w_uses_imm = w_is_i || w_is_lw || w_is_sw;
    assign w_legal    = ((w_is_r || w_is_i) && (w_funct3 != 3'b011))
                      || w_is_lw || w_is_sw
                      || (w_is_br && (w_funct3 == 3'b000 || w_funct3 == 3'b001));

    // ALU operation implied by the latched instruction
    always_comb begin
        w_alu_dec = ALU_ADD;
        if (w_is_br) begin
            w_alu_dec = ALU_SUB;
        end else if (w_is_r || w_is_i) begin
            case (w_funct3)
                3'b000:  w_alu_dec = (w_is_r && w_funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                3'b111:  w_alu_dec = ALU_AND;
                3'b110:  w_alu_dec = ALU_OR;
                3'b100:  w_alu_dec = ALU_XOR;
                3'b010:  w_alu_dec = ALU_SLT;
                3'b001:  w_alu_dec = ALU_SLL;
                3'b101:  w_alu_dec = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                default: w_alu_dec = ALU_ADD;
            endcase
        end
    end

    // Next-state and datapath strobes from state and IR
    always_comb begin
        w_state_nxt = r_state;
        IRWrite     = 1'b0;
        loadPC      = 1'b0;
        PCSrc       = 1'b0;
        ALUSrc      = 1'b0;
        ALUCtrl     = ALU_ADD;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrc      = w_uses_imm;
                w_state_nxt = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                ALUSrc  = w_uses_imm;
                ALUCtrl = w_alu_dec;
                if (w_is_br) begin
                    loadPC      = 1'b1;
                    PCSrc       = w_funct3[0] ? ~Zero : Zero;
                    w_state_nxt = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                ALUSrc   = w_uses_imm;
                ALUCtrl  = w_alu_dec;
                MemRead  = w_is_lw;
                MemWrite = w_is_sw;
                if (dReady) begin
                    if (w_is_sw) begin
                        loadPC      = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_mem_timeout) begin
                    w_state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                ALUSrc      = w_uses_imm;
                RegWrite    = 1'b1;
                loadPC      = 1'b1;
                MemToReg    = w_is_lw;
                w_state_nxt = S_FETCH;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_state_nxt;
    end

    // Instruction register, loaded in FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_ir <= INITIAL_IR;
        else if (r_state == S_FETCH) r_ir <= instr;
    end

    // Retired-instruction counter: one tick per PC update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_instret <= '0;
        else if (loadPC) r_instret <= r_instret + INSTRET_W'(1);
    end

    // Sticky illegal-instruction flag, set as DECODE hands over to TRAP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  r_illegal <= 1'b0;
        else if (r_state == S_DECODE && !w_legal)  r_illegal <= 1'b1;
    end

`ifdef MC_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_mem_err;

    assign w_mem_timeout = (r_state == S_MEM) && !dReady
                         && (r_to_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Consecutive not-ready MEM cycles; EXEC always precedes MEM entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              r_to_cnt <= '0;
        else if (r_state == S_EXEC)            r_to_cnt <= '0;
        else if (r_state == S_MEM && !dReady)  r_to_cnt <= r_to_cnt + CNT_W'(1);
    end

    // Sticky memory-timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               r_mem_err <= 1'b0;
        else if (w_mem_timeout) r_mem_err <= 1'b1;
    end

    assign mem_err  = r_mem_err;
    assign w_unused = ^{r_ir[24:15], r_ir[11:7]};
`else
    assign w_mem_timeout = 1'b0;
    assign mem_err       = 1'b0;
    assign w_unused      = ^{r_ir[24:15], r_ir[11:7], (MEM_TIMEOUT == 0)};
`endif

    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the RV32I datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, decodes ALUCtrl and all datapath strobes from a latched instruction register, and waits on a data-memory ready handshake. It also counts retired instructions and traps on illegal opcodes and, optionally, on data-memory timeout. It replaces the fixed-5-state controller inside the processor top and drives the existing datapath ports unchanged.

## Interface
- INITIAL_IR, 32'h00000013, IR reset value (NOP).
- MEM_TIMEOUT, 16, max MEM-state cycles waiting for dReady (only with timeout enabled); ≥1.
- INSTRET_W, 32, retire counter width; ≥1.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr  in  32  instruction word; valid in the FETCH cycle.
- Zero  in  1  ALU zero flag.
- dReady  in  1  data memory ready; sampled in MEM.
- IRWrite  out  1  IR capture strobe.
- loadPC  out  1  PC update strobe.
- PCSrc  out  1  1 = branch target, 0 = PC+4.
- ALUSrc  out  1  1 = immediate operand.
- ALUCtrl  out  4  ALU operation.
- MemRead  out  1  data read request.
- MemWrite  out  1  data write request.
- MemToReg  out  1  1 = write back load data.
- RegWrite  out  1  register file write strobe.
- illegal  out  1  sticky illegal-instruction trap.
- mem_err  out  1  sticky memory-timeout trap.
- instret  out  INSTRET_W  retired instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH. On reset, IR = INITIAL_IR, instret = 0, illegal = 0, mem_err = 0, timeout counter = 0.
- Outputs are combinational from the state and IR. In FETCH, only IRWrite = 1. ALUCtrl = 0010 in every state except EXEC and MEM. All other outputs are 0 unless listed below.
- FETCH: IRWrite = 1. IR <= instr. Next state is DECODE.
- DECODE: next state is EXEC if the opcode is supported, else TRAP.
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW), 1100011 (BEQ with funct3 000; BNE with funct3 001).
  - Any other opcode, or a branch with any other funct3, is illegal.
- ALUCtrl decode:
  - LW, SW, ADDI: 0010.
  - Branch: 0110.
  - R-type and I-ALU by funct3:
    - 000: ADD 0010; SUB 0110 only for R-type with funct7 = 0100000.
    - 111 AND 0000; 110 OR 0001; 100 XOR 0101; 010 SLT 0100; 001 SLL 1001.
    - 101: SRA 1010 when funct7 = 0100000, else SRL 1000.
    - 011: illegal.
- ALUSrc = 1 for I-ALU, LW and SW.
- EXEC:
  - Branch: loadPC = 1. PCSrc = Zero for BEQ, ~Zero for BNE. Next state is FETCH.
  - LW/SW: next state is MEM.
  - R/I-ALU: next state is WB.
- MEM: LW asserts MemRead = 1; SW asserts MemWrite = 1. The strobe is held until dReady = 1.
  - dReady = 1, LW: next state is WB.
  - dReady = 1, SW: loadPC = 1 in that cycle; next state is FETCH.
- WB: RegWrite = 1, loadPC = 1, MemToReg = 1 for LW. Next state is FETCH.
- instret increments on every cycle with loadPC = 1 and wraps modulo 2^INSTRET_W.
- TRAP: all strobes 0. The block stays in TRAP until reset. illegal or mem_err stays 1.
- An asynchronous reset in any state returns the block to FETCH immediately. Strobes fall without waiting for a clock edge.

## Timing
- Cycles per instruction: BEQ/BNE 3; R/I-ALU 4; SW 4 + w; LW 5 + w, where w is the number of MEM cycles with dReady = 0.
- loadPC is high for exactly one cycle, the last cycle of each instruction. The PC updates on that edge.
- RegWrite is high for exactly one cycle per R/I/LW instruction.
- dReady is ignored outside MEM. dReady = 1 on the first MEM cycle gives w = 0.
- illegal rises in the cycle after DECODE, i.e. on the first TRAP cycle.

## Configuration
- MC_CTRL_TIMEOUT_EN defined:
  - A counter counts MEM cycles with dReady = 0 and clears on MEM entry.
  - On the MEM_TIMEOUT-th consecutive such cycle the block goes to TRAP and mem_err is set.
  - dReady = 1 in that same cycle takes priority: normal completion.
- MC_CTRL_TIMEOUT_EN undefined: MEM waits indefinitely. mem_err is tied to 0 and no counter is instantiated.

## Test plan
- ADD (0x002081B3) then SUB (0x402081B3):
  - ALUCtrl 0010 / 0110 in EXEC.
  - RegWrite in cycle 4.
  - instret = 2 after 8 cycles.
- SRA R-type (0x4020D1B3) gives ALUCtrl 1010; SRL (0x0020D1B3) gives 1000.
- BEQ (0x00208463):
  - Zero = 1: PCSrc = 1 and loadPC in cycle 3.
  - BNE (0x00209463) with Zero = 1: PCSrc = 0.
- LW (0x0000A183) with dReady low for 3 MEM cycles:
  - MemRead held for 4 cycles.
  - WB with MemToReg = 1 and RegWrite = 1.
  - Total 8 cycles.
- Opcode 0x0000007F: TRAP, illegal = 1, loadPC never asserted. Drive rst = 0 mid-TRAP: immediately FETCH, illegal = 0, instret = 0.
- With MC_CTRL_TIMEOUT_EN and MEM_TIMEOUT = 4, SW with dReady held 0: mem_err = 1 after 4 MEM cycles. Without the macro: MemWrite stays 1 for 100 cycles.
